// File: rtl/dma_channel_arbiter.sv
// rtl/dma_channel_arbiter.sv - DMA request arbiter with fixed/rotating priority and HRQ/HLDA/DACK sequencing
// Optional grant watchdog enabled by defining DMA_ARB_TIMEOUT_EN.
module dma_channel_arbiter #(
  parameter int NUM_CH           = 4,
  parameter int IDW              = $clog2(NUM_CH),
  parameter int MAX_GRANT_CYCLES = 256
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [NUM_CH-1:0]     DREQ,
  input  logic [NUM_CH-1:0]     maskReg,
  input  logic                  rotatingPriority,
  input  logic                  HLDA,
  input  logic                  serviceDone,
  output logic                  HRQ,
  output logic [NUM_CH-1:0]     DACK,
  output logic [IDW-1:0]        grantId,
  output logic                  grantValid,
  output logic [NUM_CH*IDW-1:0] priorityOrder,
  output logic                  timeoutErr
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GRANT, S_RELEASE} state_e;

  state_e                state_q, state_d;
  logic                  hrq_q, hrq_d;
  logic [NUM_CH-1:0]     dack_q, dack_d;
  logic [IDW-1:0]        grant_id_q, grant_id_d;
  logic                  grant_valid_q, grant_valid_d;
  logic [NUM_CH*IDW-1:0] prio_q, prio_d;

  logic [NUM_CH-1:0]     eff_req;
  logic                  any_req;
  logic [IDW-1:0]        winner;
  logic                  rotate;
  logic                  timeout_hit;

  function automatic logic [NUM_CH*IDW-1:0] default_order();
    logic [NUM_CH*IDW-1:0] o;
    for (int k = 0; k < NUM_CH; k++) o[k*IDW +: IDW] = IDW'(k);
    return o;
  endfunction

  // Serviced channel c drops to the bottom; everything after it moves up.
  function automatic logic [NUM_CH*IDW-1:0] rotated_order(input logic [IDW-1:0] c);
    logic [NUM_CH*IDW-1:0] o;
    for (int k = 0; k < NUM_CH; k++) o[k*IDW +: IDW] = IDW'((int'(c) + 1 + k) % NUM_CH);
    return o;
  endfunction

  assign eff_req = DREQ & ~maskReg;
  assign any_req = |eff_req;

  always_comb begin
    winner = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (eff_req[prio_q[k*IDW +: IDW]]) winner = prio_q[k*IDW +: IDW];
    end
  end

`ifdef DMA_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_GRANT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;

  assign timeout_hit = (state_q == S_GRANT) && (cnt_q == CNT_W'(MAX_GRANT_CYCLES - 1));

  always_comb begin
    cnt_d         = '0;
    if (state_q == S_GRANT && state_d == S_GRANT) cnt_d = cnt_q + 1'b1;
    timeout_err_d = timeout_err_q | (timeout_hit & ~serviceDone);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeoutErr = timeout_err_q;
`else
  assign timeout_hit = 1'b0;
  assign timeoutErr  = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= S_IDLE;
      hrq_q         <= 1'b0;
      dack_q        <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      prio_q        <= default_order();
    end else begin
      state_q       <= state_d;
      hrq_q         <= hrq_d;
      dack_q        <= dack_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      prio_q        <= prio_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rotate     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d    = S_REQ;
          grant_id_d = winner;
        end
      end
      S_REQ: begin
        if (!any_req) begin
          state_d = S_IDLE;
        end else begin
          grant_id_d = winner;
          if (HLDA) state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        // serviceDone outranks both the watchdog and a simultaneous HLDA drop
        if (serviceDone) begin
          state_d = S_RELEASE;
          rotate  = rotatingPriority;
        end else if (timeout_hit) begin
          state_d = S_RELEASE;
        end else if (!HLDA) begin
          state_d = S_IDLE;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hrq_d         = (state_d == S_REQ) || (state_d == S_GRANT);
    grant_valid_d = (state_d == S_GRANT);
    dack_d        = '0;
    if (state_d == S_GRANT) dack_d[grant_id_d] = 1'b1;
    if (!rotatingPriority) prio_d = default_order();
    else if (rotate)       prio_d = rotated_order(grant_id_q);
    else                   prio_d = prio_q;
  end

  assign HRQ           = hrq_q;
  assign DACK          = dack_q;
  assign grantId       = grant_id_q;
  assign grantValid    = grant_valid_q;
  assign priorityOrder = prio_q;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// tb/tb_dma_channel_arbiter.sv - scoreboard bench for dma_channel_arbiter
module tb_dma_channel_arbiter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] DREQ;
  logic [3:0] maskReg;
  logic       rotatingPriority;
  logic       HLDA;
  logic       serviceDone;
  logic       HRQ;
  logic [3:0] DACK;
  logic [1:0] grantId;
  logic       grantValid;
  logic [7:0] priorityOrder;
  logic       timeoutErr;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] dack;
    logic [1:0] id;
    logic [7:0] prio;
  } exp_t;

  exp_t exp_q[$];
  logic gv_prev = 1'b0;

  dma_channel_arbiter #(.NUM_CH(4), .MAX_GRANT_CYCLES(8)) dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .maskReg(maskReg),
    .rotatingPriority(rotatingPriority), .HLDA(HLDA), .serviceDone(serviceDone),
    .HRQ(HRQ), .DACK(DACK), .grantId(grantId), .grantValid(grantValid),
    .priorityOrder(priorityOrder), .timeoutErr(timeoutErr)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every new grant must match the oldest expected grant.
  always @(negedge CLK) begin
    if (grantValid && !gv_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_grant actual_dack=%b expected=none", DACK);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_dack", 32'(DACK), 32'(e.dack));
        chk("sb_grant_id", 32'(grantId), 32'(e.id));
        chk("sb_prio", 32'(priorityOrder), 32'(e.prio));
        chk("sb_hrq", 32'(HRQ), 32'd1);
      end
    end
    gv_prev = grantValid;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [3:0] d, input logic [1:0] id, input logic [7:0] p);
    exp_t e;
    e.dack = d; e.id = id; e.prio = p;
    exp_q.push_back(e);
  endtask

  task automatic wait_grant();
    int n = 0;
    while (!grantValid && n < 30) begin
      tick();
      n++;
    end
    chk("wait_grant", 32'(grantValid), 32'd1);
  endtask

  task automatic serve(input logic [3:0] new_dreq);
    wait_grant();
    serviceDone = 1'b1;
    DREQ        = new_dreq;
    tick();
    serviceDone = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; DREQ = '0; maskReg = '0; rotatingPriority = 1'b0;
    HLDA = 1'b0; serviceDone = 1'b0;
    tick(); tick();
    RESET = 1'b0;
    chk("rst_hrq", 32'(HRQ), 32'd0);
    chk("rst_dack", 32'(DACK), 32'd0);
    chk("rst_grant_id", 32'(grantId), 32'd0);
    chk("rst_grant_valid", 32'(grantValid), 32'd0);
    chk("rst_prio", 32'(priorityOrder), 32'hE4);
    chk("rst_timeout", 32'(timeoutErr), 32'd0);

    // Fixed priority
    DREQ = 4'b0111; HLDA = 1'b1;
    push(4'b0001, 2'd0, 8'hE4);
    tick();
    chk("hrq_latency", 32'(HRQ), 32'd1);
    chk("req_no_dack", 32'(DACK), 32'd0);
    serve(4'b0110);
    chk("release_hrq", 32'(HRQ), 32'd0);
    chk("release_dack", 32'(DACK), 32'd0);
    push(4'b0010, 2'd1, 8'hE4);
    serve(4'b0000);

    // Rotating priority
    rotatingPriority = 1'b1; DREQ = 4'b1111;
    push(4'b0001, 2'd0, 8'hE4);
    serve(4'b1111);
    chk("rot_after_ch0", 32'(priorityOrder), 32'h39);
    push(4'b0010, 2'd1, 8'h39);
    serve(4'b1111);
    chk("rot_after_ch1", 32'(priorityOrder), 32'h4E);
    push(4'b0100, 2'd2, 8'h4E);
    serve(4'b0000);
    chk("rot_after_ch2", 32'(priorityOrder), 32'h93);

    // Back to fixed, then masking and replacement
    rotatingPriority = 1'b0;
    tick();
    chk("fixed_restore", 32'(priorityOrder), 32'hE4);
    DREQ = 4'b1110; maskReg = 4'b0010;
    push(4'b0100, 2'd2, 8'hE4);
    serve(4'b0000);
    tick(); tick();
    HLDA = 1'b0; DREQ = 4'b1110;
    tick();
    chk("mask_winner", 32'(grantId), 32'd2);
    DREQ = 4'b1111;
    tick();
    chk("replace_winner", 32'(grantId), 32'd0);
    chk("replace_no_dack", 32'(DACK), 32'd0);
    push(4'b0001, 2'd0, 8'hE4);
    HLDA = 1'b1;
    serve(4'b0000);
    tick(); tick();

    // Abort on HLDA drop, then request drop in REQ
    maskReg = '0; rotatingPriority = 1'b1; DREQ = 4'b0010;
    push(4'b0010, 2'd1, 8'hE4);
    wait_grant();
    HLDA = 1'b0;
    tick();
    chk("abort_dack", 32'(DACK), 32'd0);
    chk("abort_hrq", 32'(HRQ), 32'd0);
    chk("abort_valid", 32'(grantValid), 32'd0);
    chk("abort_prio", 32'(priorityOrder), 32'hE4);
    tick();
    chk("rereq_hrq", 32'(HRQ), 32'd1);
    DREQ = 4'b0000;
    tick();
    chk("drop_hrq", 32'(HRQ), 32'd0);

    // Reset mid-grant with a rotated order
    HLDA = 1'b1; DREQ = 4'b0001;
    push(4'b0001, 2'd0, 8'hE4);
    serve(4'b0010);
    chk("rot_pre_reset", 32'(priorityOrder), 32'h39);
    push(4'b0010, 2'd1, 8'h39);
    wait_grant();
    RESET = 1'b1;
    tick();
    RESET = 1'b0; DREQ = 4'b0000;
    chk("mid_rst_dack", 32'(DACK), 32'd0);
    chk("mid_rst_hrq", 32'(HRQ), 32'd0);
    chk("mid_rst_valid", 32'(grantValid), 32'd0);
    chk("mid_rst_prio", 32'(priorityOrder), 32'hE4);

`ifdef DMA_ARB_TIMEOUT_EN
    // Watchdog: 8 GRANT cycles without serviceDone
    DREQ = 4'b0001;
    push(4'b0001, 2'd0, 8'hE4);
    wait_grant();
    DREQ = 4'b0000;
    repeat (7) tick();
    chk("wd_still_grant", 32'(grantValid), 32'd1);
    chk("wd_no_err_yet", 32'(timeoutErr), 32'd0);
    tick();
    chk("wd_release_dack", 32'(DACK), 32'd0);
    chk("wd_err_set", 32'(timeoutErr), 32'd1);
    chk("wd_no_rotate", 32'(priorityOrder), 32'hE4);
    tick(); tick(); tick();
    chk("wd_err_sticky", 32'(timeoutErr), 32'd1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("wd_err_cleared", 32'(timeoutErr), 32'd0);
`else
    DREQ = 4'b0001;
    push(4'b0001, 2'd0, 8'hE4);
    wait_grant();
    DREQ = 4'b0000;
    repeat (12) tick();
    chk("no_wd_hold", 32'(grantValid), 32'd1);
    chk("no_wd_err", 32'(timeoutErr), 32'd0);
    HLDA = 1'b0;
    tick();
`endif

    tick(); tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_channel_arbiter.md
Name: dma_channel_arbiter

Overview:
- Parametrised DMA request arbiter and handshake sequencer. It generalises the fixed 4-channel priority logic to NUM_CH channels, with fixed or rotating priority, per-channel masking, and explicit bus hold request/acknowledge sequencing.
- Sits between the DREQ pins, the internal register file (mask, command priorityType) and the timing-control FSM.
- Drives HRQ and one-hot DACK, and exports the live priority order for checkers.

Parameters:
- NUM_CH, 4, number of DMA channels (2..16).
- IDW, $clog2(NUM_CH), width of a channel index (derived; not overridden).
- MAX_GRANT_CYCLES, 256, watchdog limit in cycles; used only with DMA_ARB_TIMEOUT_EN.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- DREQ  in  NUM_CH  per-channel request, active high, level sensitive.
- maskReg  in  NUM_CH  1 = channel masked; masked requests are ignored.
- rotatingPriority  in  1  0 = fixed priority (ch0 highest), 1 = rotating.
- HLDA  in  1  hold acknowledge from CPU.
- serviceDone  in  1  single-cycle pulse from timing control at end of the granted transfer.
- HRQ  out  1  hold request to CPU.
- DACK  out  NUM_CH  one-hot acknowledge to the granted channel.
- grantId  out  IDW  index of the latched/pending winner.
- grantValid  out  1  high while in GRANT.
- priorityOrder  out  NUM_CH*IDW  entry k in bits [k*IDW +: IDW]; entry 0 is highest priority.
- timeoutErr  out  1  sticky watchdog flag.

Behaviour:
- Effective request: effReq = DREQ & ~maskReg.
- Winner: the first entry k of priorityOrder (lowest k) whose channel has effReq set.
- Reset values:
  - state = IDLE.
  - HRQ = 0, DACK = 0, grantId = 0, grantValid = 0, timeoutErr = 0.
  - priorityOrder entry k = k (for 4 channels: 8'b11_10_01_00).
- FSM states: IDLE, REQ, GRANT, RELEASE. All outputs are registered.
- IDLE:
  - If effReq != 0: latch the winner into grantId, go to REQ; HRQ = 1 on the next cycle.
  - Otherwise stay in IDLE.
- REQ:
  - HRQ = 1. The winner is re-evaluated every cycle, so a higher-priority arrival or unmask replaces grantId.
  - If effReq == 0: go to IDLE and drop HRQ.
  - If HLDA == 1 and effReq != 0: freeze grantId, go to GRANT.
- GRANT:
  - HRQ = 1, DACK = 1 << grantId, grantValid = 1.
  - DREQ and mask changes are ignored while in GRANT.
  - On serviceDone: go to RELEASE. If rotatingPriority = 1, rotate so the serviced channel c becomes lowest: entry k = (c+1+k) mod NUM_CH.
  - If HLDA drops without serviceDone: abort to IDLE, DACK = 0, no rotation.
  - If serviceDone and HLDA drop in the same cycle, serviceDone wins.
- RELEASE: HRQ = 0, DACK = 0 for exactly one cycle, then IDLE. Re-arbitration therefore starts no earlier than 2 cycles after serviceDone.
- Fixed mode:
  - While rotatingPriority = 0, priorityOrder is reloaded with the reset value every cycle.
  - Switching 1 -> 0 restores the default order on the next cycle. Switching 0 -> 1 starts rotation from the default.
- Latency: DREQ asserted in IDLE -> HRQ after 1 cycle; HLDA sampled high in REQ -> DACK after 1 cycle.
- Invariants: DACK is always one-hot or zero; DACK != 0 implies HRQ = 1 and state = GRANT.
- serviceDone outside GRANT is ignored.
- RESET asserted in any state: all registers return to reset values on the next edge. This includes priorityOrder even mid-GRANT; DACK drops on that edge.

Optional Feature:
- DMA_ARB_TIMEOUT_EN: grant watchdog.
- Defined:
  - A counter clears on GRANT entry and increments each GRANT cycle.
  - If it reaches MAX_GRANT_CYCLES without serviceDone: force RELEASE, set timeoutErr (sticky until RESET), no rotation.
- Undefined: no counter; timeoutErr is tied 0; GRANT waits indefinitely.

Test Plan:
- Fixed order: RESET, then DREQ=4'b0111, maskReg=0, rotatingPriority=0, HLDA=1 -> HRQ=1 after 1 cycle, DACK=4'b0001 one cycle after REQ. serviceDone -> RELEASE, then DACK=4'b0010 next.
- Rotating order: rotatingPriority=1, DREQ=4'b1111, serve ch0 -> priorityOrder=8'b00_11_10_01 and next DACK=4'b0010. Serve ch1 -> 8'b01_00_11_10.
- Masking / replacement: DREQ=4'b1110, maskReg=4'b0010 -> DACK=4'b0100. In REQ (HLDA=0), DREQ0 rises -> grantId becomes 0 and DACK=4'b0001 after HLDA.
- Abort and request drop: drop HLDA mid-GRANT -> DACK=0 and IDLE next cycle, priorityOrder unchanged. DREQ drops in REQ -> HRQ=0 next cycle.
- Reset mid-grant: rotatingPriority=1, order rotated, RESET in GRANT -> next cycle DACK=0, HRQ=0, priorityOrder=8'b11_10_01_00.
- With DMA_ARB_TIMEOUT_EN and MAX_GRANT_CYCLES=8: hold GRANT with no serviceDone -> after 8 GRANT cycles RELEASE, timeoutErr=1, held until RESET.
